// File: rtl/adder_slice_sched.sv
// adder_slice_sched: two-requester add/subtract sequencer that runs each
// WIDTH-bit operation nibble-serially through a single shared 4-bit adder
// slice, LSB nibble first, with a registered carry between passes.
module adder_slice_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    nib_q, nib_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;

  logic             grant_s;
  logic             accept_s;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [4:0]       slice_s;
  logic [WIDTH-1:0] nib_pos_s;

  // Pick the 4-bit field of v addressed by the nibble counter.
  function automatic logic [3:0] nib_sel(input logic [WIDTH-1:0] v, input logic [CW-1:0] idx);
    logic [WIDTH-1:0] sh;
    sh = v >> {idx, 2'b00};
    return sh[3:0];
  endfunction

  // Round-robin grant: sole valid requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s   = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant_s;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant_s;

  // The shared 4-bit slice: current operand nibbles plus the registered carry.
  always_comb begin
    a_nib_s   = nib_sel(a_q, nib_q);
    b_nib_s   = nib_sel(b_q, nib_q);
    slice_s   = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'd0, carry_q};
    nib_pos_s = WIDTH'({nib_q, 2'b00});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, NIB slice passes in CALC, wait for consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (nib_q == LAST_NIB) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath/output next values: capture on accept, one nibble per CALC cycle, handoff in DONE.
  always_comb begin
    last_d      = last_q;
    nib_d       = nib_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          // B is stored pre-inverted for subtract; the +1 enters as the initial carry.
          if (grant_s) begin
            a_d     = req1_a;
            b_d     = req1_sub ? ~req1_b : req1_b;
            carry_d = req1_sub;
          end else begin
            a_d     = req0_a;
            b_d     = req0_sub ? ~req0_b : req0_b;
            carry_d = req0_sub;
          end
          last_d = grant_s;
          nib_d  = {CW{1'b0}};
        end else begin
          nib_d = nib_q;
        end
      end
      CALC: begin
        res_sum_d = (res_sum_q & ~(WIDTH'(4'hF) << nib_pos_s))
                  | (WIDTH'(slice_s[3:0]) << nib_pos_s);
        carry_d   = slice_s[4];
        nib_d     = nib_q + CW'(1);
        if (nib_q == LAST_NIB) begin
          res_cout_d  = slice_s[4];
          res_ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          res_id_d    = last_q;
          res_valid_d = 1'b1;
        end else begin
          res_valid_d = 1'b0;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and result registers; pointer resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      nib_q       <= {CW{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      res_sum_q   <= {WIDTH{1'b0}};
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      nib_q       <= nib_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_slice_sched.sv
// Self-checking bench for adder_slice_sched (WIDTH=16): directed and random
// operations compared against an integer-arithmetic reference model.
module tb_adder_slice_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sub;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready;
  logic [15:0] res_sum;
  logic        res_cout, res_ovf, res_id, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] corners [0:5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h8001};

  adder_slice_sched #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the whole word.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                output logic [15:0] s, output logic c, output logic o);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb);
    s  = r[15:0];
    o  = (r > 32767) || (r < -32768);
    if (sub) c = (a >= b);
    else     c = ((int'(a) + int'(b)) > 65535);
  endfunction

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    else return 16'($urandom);
  endfunction

  task automatic scramble();
    req0_a = pick(); req0_b = pick(); req0_sub = 1'($urandom);
    req1_a = pick(); req1_b = pick(); req1_sub = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_sum"}, res_sum, 0);
    chk({tag, "_cout"}, res_cout, 0);
    chk({tag, "_ovf"}, res_ovf, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One operation from requester r with bp cycles of result backpressure.
  // Called at posedge+1 with the DUT idle.
  task automatic run_op(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input int bp);
    logic [15:0] es;
    logic ec, eo;
    int n;
    model(a, b, sub, es, ec, eo);
    if (r) begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
    end
    @(negedge clk);
    n = 0;
    while (!(r ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n, 0);
    chk("other_ready", r ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    scramble();
    n = 0;
    while (!res_valid && n < 10) begin
      chk("busy_calc", busy, 1);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 4);
    chk("sum", res_sum, es);
    chk("cout", res_cout, ec);
    chk("ovf", res_ovf, eo);
    chk("id", res_id, r);
    chk("busy_done", busy, 1);
    for (int k = 0; k < bp; k++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_valid", res_valid, 1);
      chk("bp_sum", res_sum, es);
      chk("bp_flags", {res_cout, res_ovf, res_id}, {ec, eo, r});
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    res_ready  = 1'b0;
    chk("handoff_valid", res_valid, 0);
    chk("handoff_hold", {res_sum, res_cout, res_ovf, res_id}, {es, ec, eo, r});
    chk("handoff_busy", busy, 0);
  endtask

  logic [15:0] qs[$];
  logic [2:0]  qf[$];
  int          acc_id[$];
  int          acc_cyc[$];

  initial begin
    logic [15:0] es;
    logic ec, eo, a0, a1;
    logic [15:0] ra, rb;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = 16'h0; req0_b = 16'h0; req0_sub = 1'b0;
    req1_a = 16'h0; req1_b = 16'h0; req1_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    rst = 1'b0;

    // Arbitration: both valid continuously, consumer always ready.
    scramble();
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      if (req0_ready) begin
        model(req0_a, req0_b, req0_sub, es, ec, eo);
        qs.push_back(es); qf.push_back({ec, eo, 1'b0});
        acc_id.push_back(0); acc_cyc.push_back(cyc);
      end
      if (req1_ready) begin
        model(req1_a, req1_b, req1_sub, es, ec, eo);
        qs.push_back(es); qf.push_back({ec, eo, 1'b1});
        acc_id.push_back(1); acc_cyc.push_back(cyc);
      end
      if (res_valid) begin
        chk("arb_res_pending", qs.size() > 0, 1);
        if (qs.size() > 0) begin
          chk("arb_sum", res_sum, qs.pop_front());
          chk("arb_flags", {res_cout, res_ovf, res_id}, qf.pop_front());
        end
      end
      a0 = req0_ready;
      a1 = req1_ready;
      @(posedge clk); #1;
      if (a0) begin req0_a = pick(); req0_b = pick(); req0_sub = 1'($urandom); end
      if (a1) begin req1_a = pick(); req1_b = pick(); req1_sub = 1'($urandom); end
      if (cyc == 39) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    res_ready = 1'b0;
    chk("arb_count", acc_id.size(), 7);
    chk("arb_drained", qs.size(), 0);
    for (int i = 0; i < acc_id.size(); i++) begin
      chk("arb_order", acc_id[i], i % 2);
      if (i > 0) chk("arb_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
    end

    // Directed vectors.
    run_op(1'b0, 16'h1234, 16'h0FCD, 1'b0, 3);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 0);
    run_op(1'b0, 16'h0007, 16'h0005, 1'b1, 1);
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 2);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b1, 0);

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      ra = pick();
      rb = pick();
      run_op(1'($urandom), ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset in the second CALC cycle discards the operation.
    req0_a = 16'h4321; req0_b = 16'h1111; req0_sub = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_op_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_valid", res_valid, 0);
    end
    @(posedge clk); #1;
    // Tie after reset must go to req0.
    req1_a = 16'h0101; req1_b = 16'h0202; req1_sub = 1'b0; req1_valid = 1'b1;
    run_op(1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
